// File: rtl/ex_result_stage.sv
// EX/MEM result register with an iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divides stall the upstream pipeline for a fixed 34-cycle latency, then deliver through the same register.
module ex_result_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [XLEN-1:0] alu_out,
  input  logic            is_div,
  input  logic [1:0]      div_op,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            hold,
  input  logic            flush,
  output logic            stall_out,
  output logic            valid_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            reg_write_out
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div_zero_q, div_zero_d;
  logic            is_rem_q, is_rem_d;
  logic [4:0]      div_rd_q, div_rd_d;
  logic            div_we_q, div_we_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;

  logic            op_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] quo_fix, rem_fix, div_res;

  // Signed ops divide magnitudes; signs are reapplied once iteration is complete.
  assign op_signed = ~div_op[0];
  assign a_neg     = op_signed & A[XLEN-1];
  assign b_neg     = op_signed & B[XLEN-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
  assign div_res = is_rem_q ? rem_fix : (div_zero_q ? '1 : quo_fix);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    is_rem_d   = is_rem_q;
    div_rd_d   = div_rd_q;
    div_we_d   = div_we_q;
    valid_d    = valid_q;
    result_d   = result_q;
    rd_d       = rd_q;
    we_d       = we_q;

    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hold) begin
            if (valid_in && is_div) begin
              state_d    = S_BUSY;
              count_d    = CW'(XLEN);
              rem_d      = '0;
              quo_d      = a_mag;
              dvsr_d     = b_mag;
              neg_quo_d  = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
              div_zero_d = (B == '0);
              is_rem_d   = div_op[1];
              div_rd_d   = rd_in;
              div_we_d   = reg_write_in;
              valid_d    = 1'b0;
              we_d       = 1'b0;
            end else if (valid_in) begin
              valid_d  = 1'b1;
              result_d = alu_out;
              rd_d     = rd_in;
              we_d     = reg_write_in;
            end else begin
              valid_d = 1'b0;
              we_d    = 1'b0;
            end
          end
        end
        S_BUSY: begin
          // Restoring step: keep the trial subtraction only when it did not borrow.
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (!hold) begin
            result_d = div_res;
            rd_d     = div_rd_q;
            we_d     = div_we_q;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      is_rem_q   <= 1'b0;
      div_rd_q   <= '0;
      div_we_q   <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      is_rem_q   <= is_rem_d;
      div_rd_q   <= div_rd_d;
      div_we_q   <= div_we_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
    end
  end

  assign stall_out     = (state_q != S_IDLE) | (valid_in & (hold | is_div));
  assign valid_out     = valid_q;
  assign result_out    = result_q;
  assign rd_out        = rd_q;
  assign reg_write_out = we_q & valid_q;

endmodule
